// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: time-multiplexed FIR controller sharing one
// rad4_odd_trunc multiplier across up to 16 taps, one tap per cycle.
// Optional feature macro: FIR_SAT_EN (saturate output to signed 32-bit).

// Approximate multiplier: the low five coefficient bits are ignored,
// then the Q1.10 product is scaled back with an arithmetic shift.
module rad4_odd_trunc (
  input  logic signed [31:0] x_i,
  input  logic signed [10:0] y_i,
  output logic signed [32:0] p_o
);
  logic signed [10:0] ym;
  logic signed [42:0] full;

  assign ym   = y_i & 11'sh7E0;
  assign full = 43'(x_i) * 43'(ym);
  assign p_o  = 33'(full >>> 10);
endmodule

module fir_tap_sequencer #(
  parameter int NTAPS = 4,
  parameter int ACC_W = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  input  logic        coef_we,
  input  logic [3:0]  coef_addr,
  input  logic [10:0] coef_wdata,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_e;

  localparam logic [3:0] LAST = 4'(NTAPS - 1);

  state_e state_q, state_d;

  // Storage is sized for the 16-tap maximum; entries at or above NTAPS are
  // never written (pointer wraps at NTAPS, writes are range-checked) and stay zero.
  logic [15:0][31:0]        delay_q;
  logic [15:0][10:0]        coef_q;
  logic [3:0]               wptr_q;
  logic [3:0]               rd_q;   // delay-line read index, registered so the mux select is a flop
  logic [3:0]               k_q;    // tap / coefficient index
  logic signed [32:0]       prod_q, prod_d;
  logic signed [ACC_W-1:0]  acc_q, acc_fin;
  logic [31:0]              m_data_q, res;
  logic                     coef_ok;

  assign coef_ok = (state_q == IDLE) && coef_we && ({1'b0, coef_addr} < 5'(NTAPS));
  assign acc_fin = acc_q + ACC_W'(prod_q);
  assign m_data  = m_data_q;

  rad4_odd_trunc u_mul (
    .x_i (delay_q[rd_q]),
    .y_i (coef_q[k_q]),
    .p_o (prod_d)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (s_valid) state_d = MAC;
      end
      MAC:   if (k_q == LAST) state_d = DRAIN;
      DRAIN: state_d = OUT;
      OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output formatting of the final accumulator value
`ifdef FIR_SAT_EN
  always_comb begin
    res = acc_fin[31:0];
    if (!(&acc_fin[ACC_W-1:31] || ~|acc_fin[ACC_W-1:31]))
      res = acc_fin[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end
`else
  assign res = acc_fin[31:0];
`endif

  // Datapath: coefficient bank, delay line, product pipeline and accumulator.
  // The accumulator lags the product register by one cycle, hence DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      delay_q  <= '0;
      coef_q   <= '0;
      wptr_q   <= '0;
      rd_q     <= '0;
      k_q      <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      m_data_q <= '0;
    end else begin
      if (coef_ok) coef_q[coef_addr] <= coef_wdata;
      case (state_q)
        IDLE: if (s_valid) begin
          delay_q[wptr_q] <= s_data;
          rd_q            <= wptr_q;
          k_q             <= '0;
          acc_q           <= '0;
          prod_q          <= '0;
        end
        MAC: begin
          prod_q <= prod_d;
          acc_q  <= acc_fin;
          k_q    <= k_q + 4'd1;
          rd_q   <= (rd_q == 4'd0) ? LAST : rd_q - 4'd1;
        end
        DRAIN: begin
          acc_q    <= acc_fin;
          m_data_q <= res;
          wptr_q   <= (wptr_q == LAST) ? 4'd0 : wptr_q + 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer (NTAPS = 4).
module tb_fir_tap_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_data;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [10:0] coef_wdata = '0;
  logic        busy;

  int n_cmp = 0;
  int n_mis = 0;

`ifdef FIR_SAT_EN
  localparam logic [31:0] SAT_EXP = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] SAT_EXP = 32'hEFFF_FFFC;
`endif

  fir_tap_sequencer #(.NTAPS(4), .ACC_W(36)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_coef(input logic [3:0] a, input logic [10:0] v);
    coef_we = 1'b1; coef_addr = a; coef_wdata = v;
    tick();
    coef_we = 1'b0;
  endtask

  // Send one sample, wait (bounded) for m_valid, then handshake it.
  // cyc is the cycle number of m_valid relative to the accept edge, -1 on timeout.
  task automatic run_sample(input logic [31:0] d, output int cyc, output logic [31:0] res);
    s_valid = 1'b1; s_data = d;
    tick();
    s_valid = 1'b0;
    cyc = 1;
    while (!m_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    res = m_data;
    if (!m_valid) cyc = -1;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (s_ready !== 1'b1) begin n_mis++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_mis++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_cmp++; if (m_data !== 32'd0) begin n_mis++; $display("FAIL reset_m_data got %0h want 0", m_data); end
    n_cmp++; if (busy !== 1'b0)    begin n_mis++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single_tap();
    int cyc; logic [31:0] r;
    do_reset();
    write_coef(4'd0, 11'h200);
    run_sample(32'd1000, cyc, r);
    n_cmp++; if (r !== 32'd500) begin n_mis++; $display("FAIL single_tap_data got %0d want 500", r); end
    n_cmp++; if (cyc !== 6)     begin n_mis++; $display("FAIL single_tap_latency got %0d want 6", cyc); end
    n_cmp++; if (s_ready !== 1'b1) begin n_mis++; $display("FAIL single_tap_s_ready_after got %b want 1", s_ready); end
  endtask

  task automatic test_impulse();
    int cyc; logic [31:0] r;
    logic [31:0] smp [4] = '{32'd4096, 32'd0, 32'd0, 32'd0};
    logic [31:0] exp [4] = '{32'd1024, 32'd2048, 32'd3072, 32'd0};
    do_reset();
    write_coef(4'd0, 11'h100);
    write_coef(4'd1, 11'h200);
    write_coef(4'd2, 11'h300);
    write_coef(4'd3, 11'h000);
    for (int i = 0; i < 4; i++) begin
      run_sample(smp[i], cyc, r);
      n_cmp++; if (r !== exp[i]) begin n_mis++; $display("FAIL impulse_out%0d got %0d want %0d", i, r, exp[i]); end
      n_cmp++; if (cyc !== 6) begin n_mis++; $display("FAIL impulse_latency%0d got %0d want 6", i, cyc); end
    end
  endtask

  task automatic test_backpressure();
    int cyc; int bad; logic [31:0] r;
    do_reset();
    write_coef(4'd0, 11'h200);
    write_coef(4'd1, 11'h200);
    s_valid = 1'b1; s_data = 32'd1000;
    tick();
    s_valid = 1'b0;
    cyc = 1;
    while (!m_valid && cyc < 20) begin tick(); cyc++; end
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 32'd500) begin
      n_mis++; $display("FAIL bp_first got valid=%b data=%0d want valid=1 data=500", m_valid, m_data);
    end
    s_valid = 1'b1; s_data = 32'd777;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_valid !== 1'b1 || m_data !== 32'd500 || s_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_mis++; $display("FAIL bp_hold got %0d bad cycles want 0", bad); end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0; s_valid = 1'b0;
    n_cmp++; if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_mis++; $display("FAIL bp_release got s_ready=%b m_valid=%b want 1/0", s_ready, m_valid);
    end
    // Held sample must not have entered the delay line: 0*c0 + 1000*c1 = 500.
    run_sample(32'd0, cyc, r);
    n_cmp++; if (r !== 32'd500) begin n_mis++; $display("FAIL bp_next got %0d want 500", r); end
  endtask

  task automatic test_saturation();
    int cyc; logic [31:0] r;
    do_reset();
    for (int i = 0; i < 4; i++) write_coef(4'(i), 11'h3E0);
    run_sample(32'h7FFF_FFFF, cyc, r);
    n_cmp++; if (r !== 32'h7BFF_FFFF) begin n_mis++; $display("FAIL sat_first got %0h want 7bffffff", r); end
    for (int i = 0; i < 3; i++) run_sample(32'h7FFF_FFFF, cyc, r);
    n_cmp++; if (r !== SAT_EXP) begin n_mis++; $display("FAIL sat_fourth got %0h want %0h", r, SAT_EXP); end
  endtask

  task automatic test_reset_mid_mac();
    int cyc; int pulses; logic [31:0] r;
    do_reset();
    write_coef(4'd0, 11'h200);
    s_valid = 1'b1; s_data = 32'd1000;
    tick();
    s_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (s_ready !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0) begin
      n_mis++; $display("FAIL midrst_idle got s_ready=%b busy=%b m_valid=%b want 1/0/0", s_ready, busy, m_valid);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (m_valid !== 1'b0) pulses++; end
    n_cmp++; if (pulses !== 0) begin n_mis++; $display("FAIL midrst_no_valid got %0d pulses want 0", pulses); end
    write_coef(4'd0, 11'h200);
    run_sample(32'd1000, cyc, r);
    n_cmp++; if (r !== 32'd500) begin n_mis++; $display("FAIL midrst_after got %0d want 500", r); end
  endtask

  task automatic test_busy_coef_write();
    int cyc; logic [31:0] r;
    do_reset();
    write_coef(4'd0, 11'h200);
    write_coef(4'd4, 11'h300);   // out of range for 4 taps
    s_valid = 1'b1; s_data = 32'd1000;
    tick();
    s_valid = 1'b0;
    tick();
    coef_we = 1'b1; coef_addr = 4'd0; coef_wdata = 11'h300;
    tick();
    coef_we = 1'b0;
    cyc = 3;
    while (!m_valid && cyc < 20) begin tick(); cyc++; end
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 32'd500) begin
      n_mis++; $display("FAIL busywr_first got valid=%b data=%0d want 1/500", m_valid, m_data);
    end
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    run_sample(32'd1000, cyc, r);
    n_cmp++; if (r !== 32'd500) begin n_mis++; $display("FAIL busywr_second got %0d want 500", r); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_tap();
    test_impulse();
    test_backpressure();
    test_saturation();
    test_reset_mid_mac();
    test_busy_coef_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
